// File: rtl/dpc_bp_capture_ctrl.sv
// One-frame bad-pixel capture sequencer for the DPC detector: captures reported
// pixels into a local table, serves host reads, and appends the table to the manual LUT.
module dpc_bp_capture_ctrl #(
  parameter int CNT_WIDTH     = 10,
  parameter int AUTO_BP_NUM   = 256,
  parameter int AUTO_BP_BIT   = 8,
  parameter int MANUAL_BP_NUM = 128,
  parameter int MANUAL_BP_BIT = 7
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     arm,
  input  logic                     commit,
  input  logic                     abort,
  input  logic                     frame_start,
  input  logic                     frame_done,
  input  logic                     det_bp_valid,
  input  logic [CNT_WIDTH-1:0]     det_bp_x,
  input  logic [CNT_WIDTH-1:0]     det_bp_y,
  input  logic                     det_bp_type,
  output logic                     det_bp_ready,
  output logic                     det_enable,
  input  logic [AUTO_BP_BIT-1:0]   rd_addr,
  output logic [31:0]              rd_data,
  input  logic [MANUAL_BP_BIT-1:0] manual_bp_num_i,
  output logic                     manual_wen,
  output logic [MANUAL_BP_BIT-1:0] manual_waddr,
  output logic [31:0]              manual_wdata,
  output logic [MANUAL_BP_BIT-1:0] manual_bp_num_o,
  output logic [AUTO_BP_BIT:0]     bp_count,
  output logic [AUTO_BP_BIT:0]     dead_count,
  output logic [AUTO_BP_BIT:0]     stuck_count,
  output logic                     overflow,
  output logic                     commit_trunc,
  output logic                     busy,
  output logic                     done
);

  // Position width wide enough to hold base + index without wrapping.
  localparam int PW = ((AUTO_BP_BIT > MANUAL_BP_BIT) ? AUTO_BP_BIT : MANUAL_BP_BIT) + 2;
  localparam logic [AUTO_BP_BIT:0] TABLE_FULL = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);
  localparam logic [AUTO_BP_BIT:0] CNT_ONE    = (AUTO_BP_BIT+1)'(1);
  localparam logic [PW-1:0]        LUT_DEPTH  = PW'(MANUAL_BP_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DONE,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_busy;
  logic                     r_done;
  logic                     r_det_enable;
  logic [AUTO_BP_BIT:0]     r_bp_count;
  logic [AUTO_BP_BIT:0]     r_dead_count;
  logic [AUTO_BP_BIT:0]     r_stuck_count;
  logic                     r_overflow;
  logic                     r_commit_trunc;

  // Table holds {type, x[9:0], y[9:0]}; the 32-bit host view is formatted on read.
  logic [20:0]              r_table [AUTO_BP_NUM];
  logic [20:0]              r_rd_q;
  logic [19:0]              r_cm_q;

  logic [MANUAL_BP_BIT-1:0] r_cm_base;
  logic [AUTO_BP_BIT:0]     r_cm_idx;
  logic                     r_cm_stop;
  logic                     r_cm_p1_vld;
  logic [MANUAL_BP_BIT-1:0] r_cm_p1_addr;
  logic                     r_manual_wen;
  logic [MANUAL_BP_BIT-1:0] r_manual_waddr;
  logic [31:0]              r_manual_wdata;
  logic [MANUAL_BP_BIT-1:0] r_manual_bp_num;

  logic                     w_arm_accept;
  logic                     w_commit_accept;
  logic                     w_cap_wr;
  logic                     w_cap_store;
  logic [20:0]              w_entry;
  logic [PW-1:0]            w_cm_pos;
  logic                     w_cm_lut_full;
  logic                     w_cm_more;
  logic                     w_cm_active;
  logic                     w_cm_issue;
  logic                     w_cm_exit;

  assign w_arm_accept    = !abort && arm && (r_state == S_IDLE || r_state == S_DONE);
  assign w_commit_accept = !abort && commit && !arm && (r_state == S_DONE);

  assign w_cap_wr    = !abort && (r_state == S_CAPTURE) && det_bp_valid;
  assign w_cap_store = w_cap_wr && (r_bp_count != TABLE_FULL);
  assign w_entry     = {det_bp_type, 10'(det_bp_x), 10'(det_bp_y)};

  assign w_cm_pos      = PW'(r_cm_base) + PW'(r_cm_idx);
  assign w_cm_lut_full = (w_cm_pos >= LUT_DEPTH);
  assign w_cm_more     = (r_cm_idx < r_bp_count);
  assign w_cm_active   = !abort && (r_state == S_COMMIT);
  assign w_cm_issue    = w_cm_active && !r_cm_stop && w_cm_more && !w_cm_lut_full;
  // Exit once issuing has stopped and the read stage has drained into the write stage.
  assign w_cm_exit     = w_cm_active && r_cm_stop && !r_cm_p1_vld;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (arm)         w_state_nxt = S_WAIT_SOF;
        S_WAIT_SOF: if (frame_start) w_state_nxt = S_CAPTURE;
        S_CAPTURE:  if (frame_done)  w_state_nxt = S_DONE;
        S_DONE: begin
          if (arm)         w_state_nxt = S_WAIT_SOF;
          else if (commit) w_state_nxt = S_COMMIT;
        end
        S_COMMIT:   if (w_cm_exit)   w_state_nxt = S_DONE;
        default:                     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_det_enable    <= 1'b0;
      r_bp_count      <= '0;
      r_dead_count    <= '0;
      r_stuck_count   <= '0;
      r_overflow      <= 1'b0;
      r_commit_trunc  <= 1'b0;
      r_cm_base       <= '0;
      r_cm_idx        <= '0;
      r_cm_stop       <= 1'b0;
      r_cm_p1_vld     <= 1'b0;
      r_cm_p1_addr    <= '0;
      r_manual_wen    <= 1'b0;
      r_manual_waddr  <= '0;
      r_manual_wdata  <= '0;
      r_manual_bp_num <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt == S_WAIT_SOF) || (w_state_nxt == S_CAPTURE) ||
                      (w_state_nxt == S_COMMIT);
      r_done       <= (w_state_nxt == S_DONE);
      r_det_enable <= (w_state_nxt == S_WAIT_SOF) || (w_state_nxt == S_CAPTURE);

      if (w_arm_accept) begin
        r_bp_count     <= '0;
        r_dead_count   <= '0;
        r_stuck_count  <= '0;
        r_overflow     <= 1'b0;
        r_commit_trunc <= 1'b0;
      end else if (w_cap_wr) begin
        if (!w_cap_store) begin
          r_overflow <= 1'b1;
        end else begin
          r_bp_count <= r_bp_count + CNT_ONE;
          if (det_bp_type) r_stuck_count <= r_stuck_count + CNT_ONE;
          else             r_dead_count  <= r_dead_count + CNT_ONE;
        end
      end

      r_manual_wen <= 1'b0;
      if (w_commit_accept) begin
        r_cm_base   <= manual_bp_num_i;
        r_cm_idx    <= '0;
        r_cm_stop   <= 1'b0;
        r_cm_p1_vld <= 1'b0;
      end else if (w_cm_active) begin
        if (w_cm_issue) begin
          r_cm_p1_vld  <= 1'b1;
          r_cm_p1_addr <= r_cm_base + r_cm_idx[MANUAL_BP_BIT-1:0];
          r_cm_idx     <= r_cm_idx + CNT_ONE;
        end else begin
          r_cm_p1_vld <= 1'b0;
          if (!r_cm_stop) begin
            r_cm_stop <= 1'b1;
            if (w_cm_more && w_cm_lut_full) r_commit_trunc <= 1'b1;
          end
        end
        r_manual_wen   <= r_cm_p1_vld;
        r_manual_waddr <= r_cm_p1_addr;
        r_manual_wdata <= {6'b0, r_cm_q[19:10], 6'b0, r_cm_q[9:0]};
        if (w_cm_exit) r_manual_bp_num <= r_cm_base + r_cm_idx[MANUAL_BP_BIT-1:0];
      end
    end
  end

  // NOTE: the capture table is a plain RAM with no reset; reads beyond bp_count are stale by design.
  always_ff @(posedge aclk) begin
    if (w_cap_store) r_table[r_bp_count[AUTO_BP_BIT-1:0]] <= w_entry;
    r_rd_q <= r_table[rd_addr];
    if (w_cm_issue) r_cm_q <= r_table[r_cm_idx[AUTO_BP_BIT-1:0]][19:0];
  end

  assign det_bp_ready    = 1'b1;
  assign det_enable      = r_det_enable;
  assign rd_data         = {r_rd_q[20], 5'b0, r_rd_q[19:10], 6'b0, r_rd_q[9:0]};
  assign manual_wen      = r_manual_wen;
  assign manual_waddr    = r_manual_waddr;
  assign manual_wdata    = r_manual_wdata;
  assign manual_bp_num_o = r_manual_bp_num;
  assign bp_count        = r_bp_count;
  assign dead_count      = r_dead_count;
  assign stuck_count     = r_stuck_count;
  assign overflow        = r_overflow;
  assign commit_trunc    = r_commit_trunc;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
